mdu_seq: RTL

Iterative RV32M multiply/divide unit in the EX stage of the pipelined core. It accepts one M-extension operation from the EX stage and computes it over a fixed number of cycles. While it works, it drives `stall`, which holds the IF/ID, ID/EX and PC enable-registers. It returns the result to the EX result mux in the cycle it releases the stall.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the iterative RV32M multiply/divide unit.
//   mdu_op_e    - funct3 encoding of the M-extension operations
//   mdu_state_e - control FSM states (IDLE, RUN, DONE)
//   is_div()    - true for DIV/DIVU/REM/REMU
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step.
//   rem_in       - current partial remainder (always < divisor)
//   dividend_bit - next dividend bit shifted into the remainder
//   divisor      - divisor magnitude
//   rem_out      - next partial remainder
//   q_bit        - quotient bit produced by this step
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  // XLEN+1-bit partial remainder after the shift.
  logic [XLEN:0]   partial;
  logic [XLEN-1:0] diff;

  assign partial = {rem_in, dividend_bit};
  assign q_bit   = (partial >= {1'b0, divisor});
  // When the subtraction succeeds the true difference is below the divisor,
  // so the low XLEN bits of the subtraction are exact.
  assign diff    = partial[XLEN-1:0] - divisor;
  assign rem_out = q_bit ? diff : partial[XLEN-1:0];

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit for the EX stage.
//
// Handshake: EX raises `start` with op/a/b and keeps it (and the operands)
// steady until `done`. `done` is a one-cycle pulse with `result` valid in the
// same cycle; `stall` = start & ~done freezes the upstream pipeline, so the
// pipeline advances on the edge that ends DONE. A new op is only accepted in
// IDLE. `kill` aborts any state back to IDLE without `done` and without
// touching `result`, and outranks `start`.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start, op     - request and funct3 operation (mdu_op_e encoding)
//   a, b          - rs1 / rs2 operands
//   kill          - EX flush
//   stall, busy   - pipeline hold, unit occupied (RUN or DONE)
//   done, result  - completion pulse, registered result
//   dbg_state     - current FSM state for observation
//
// Build option: MDU_FAST_MUL_EN makes all multiplies single-cycle
// (IDLE -> DONE through a combinational multiplier); divides stay iterative.
// Without it there is no multiplier, only the shift-add datapath.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e state, state_next;
  logic [CW-1:0]     cnt;
  mdu_op_e           op_q;
  logic              neg_q;   // final result must be negated
  logic [XLEN-1:0]   opb_q;   // |b|: multiplicand or divisor
  // Multiply: {partial product high, multiplier/low product}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept time
  // ---------------------------------------------------------------------------
  mdu_op_e         op_in;
  logic            accept;
  logic            a_signed, b_signed, a_neg, b_neg, b_zero;
  logic            neg_in;
  logic [XLEN-1:0] abs_a, abs_b;

  assign op_in    = mdu_op_e'(op);
  assign accept   = (state == IDLE) && start && !kill;
  // Unsigned forms: MULHU, DIVU, REMU (divide unsigned ops have funct3[0]=1).
  assign a_signed = (op_in != MULHU) && !(is_div(op_in) && op[0]);
  assign b_signed = is_div(op_in) ? !op[0] : (op_in == MUL || op_in == MULH);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign b_zero   = (b == '0);
  assign abs_a    = a_neg ? -a : a;
  assign abs_b    = b_neg ? -b : b;

  // Remainder follows the dividend. The quotient of a divide by zero must
  // stay all ones, so its sign is forced positive.
  always_comb begin
    neg_in = a_neg ^ b_neg;
    if (is_div(op_in)) begin
      if (op_in == REM || op_in == REMU) neg_in = a_neg;
      else                               neg_in = (a_neg ^ b_neg) && !b_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional single-cycle multiplier
  // ---------------------------------------------------------------------------
  logic            fast_mul_go;
  logic [XLEN-1:0] fast_res;

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN+1:0] fa, fb, fprod;

  // Sign-extend to the full product width; the low bits of the modular
  // product equal the signed/unsigned mixed product.
  assign fa          = {{(XLEN+2){a_neg}}, a} ;
  assign fb          = {{(XLEN+2){b_neg}}, b} ;
  assign fprod       = fa[2*XLEN+1:0] * fb[2*XLEN+1:0];
  assign fast_mul_go = !is_div(op_in);
  assign fast_res    = (op_in == MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast_mul_go = 1'b0;
  assign fast_res    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Iterative datapath: one step per RUN cycle
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, mul_fix;
  logic [XLEN-1:0]   div_rem, q_mag, r_mag, fin;
  logic              div_q;

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (acc[2*XLEN-1:XLEN]),
    .dividend_bit (acc[XLEN-1]),
    .divisor      (opb_q),
    .rem_out      (div_rem),
    .q_bit        (div_q)
  );

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign div_next = {div_rem, acc[XLEN-2:0], div_q};
  assign acc_next = is_div(op_q) ? div_next : mul_next;

  // Sign fix applied to the value produced by the final step.
  always_comb begin
    mul_fix = neg_q ? -acc_next : acc_next;
    q_mag   = acc_next[XLEN-1:0];
    r_mag   = acc_next[2*XLEN-1:XLEN];
    fin     = '0;
    case (op_q)
      MUL:                 fin = mul_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: fin = mul_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           fin = neg_q ? -q_mag : q_mag;
      REM, REMU:           fin = neg_q ? -r_mag : r_mag;
      default:             fin = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = fast_mul_go ? DONE : RUN;
      RUN:  if (cnt == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill) state_next = IDLE;
  end

  // ---------------------------------------------------------------------------
  // State, counter, operand and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= MUL;
      neg_q  <= 1'b0;
      opb_q  <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_in;
            opb_q <= abs_b;
            acc   <= {{XLEN{1'b0}}, abs_a};
            cnt   <= CW'(XLEN - 1);
            if (fast_mul_go) result <= fast_res;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
          // Last step: result becomes visible in DONE, unless flushed.
          if (cnt == '0 && !kill) result <= fin;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign stall     = start & ~done;
  assign dbg_state = state;

endmodule
